// File: rtl/bus_slave_responder_pkg.sv
// bus_slave_responder_pkg: shared serial-bus constants, read/write encoding and FSM state codes
package bus_slave_responder_pkg;
  localparam int BUS_ADDR_WIDTH = 4;
  localparam int BUS_DATA_WIDTH = 8;
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ = 1'b0;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;
endpackage

// File: rtl/bus_slave_responder_regfile.sv
// slave_regfile: register file with synchronous write, combinational read and synchronous clear
module slave_regfile #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (reset) r_mem <= '{default: '0};
    else if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/bus_slave_responder.sv
// bus_slave_responder: serial bus endpoint decoding start/address/data frames into a local register file
module bus_slave_responder
  import bus_slave_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH  = BUS_DATA_WIDTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic                  m_valid,
  input  logic                  m_rw,
  input  logic                  m_sdata,
  output logic                  s_sdata,
  output logic                  s_valid,
  output logic                  s_ready,
  output logic [2:0]            slave_state,
  output logic [DATA_WIDTH-1:0] last_rdata
);
  localparam int CW = $clog2(ADDR_WIDTH + DATA_WIDTH + WAIT_CYCLES + 1);
  logic [2:0] r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_rw;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_sh, w_raddr;
  logic [DATA_WIDTH-1:0] r_data, r_shift, r_last, w_data_sh, w_rot, w_rdata;
  logic w_last_a, w_last_d, w_last_w, w_we, w_wr;
  assign w_addr_sh = {m_sdata, r_addr[ADDR_WIDTH-1:1]};
  assign w_data_sh = {m_sdata, r_data[DATA_WIDTH-1:1]};
  assign w_rot = {r_shift[0], r_shift[DATA_WIDTH-1:1]};
  assign w_last_a = r_cnt == CW'(ADDR_WIDTH - 1);
  assign w_last_d = r_cnt == CW'(DATA_WIDTH - 1);
  assign w_last_w = r_cnt == CW'(WAIT_CYCLES - 1);
  assign w_wr = r_rw == RW_WRITE;
  assign w_we = r_state == ST_WDATA && sel && w_last_d;
  assign w_raddr = r_state == ST_ADDR ? w_addr_sh : r_addr;
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_next = (sel && m_valid) ? ST_ADDR : ST_IDLE;
      ST_ADDR:  w_next = !sel ? ST_IDLE : !w_last_a ? ST_ADDR : w_wr ? ST_WDATA :
                         (WAIT_CYCLES > 0) ? ST_WAIT : ST_RDATA;
      ST_WDATA: w_next = !sel ? ST_IDLE : !w_last_d ? ST_WDATA : (WAIT_CYCLES > 0) ? ST_WAIT : ST_DONE;
      ST_WAIT:  w_next = !sel ? ST_IDLE : !w_last_w ? ST_WAIT : w_wr ? ST_DONE : ST_RDATA;
      ST_RDATA: w_next = !sel ? ST_IDLE : !w_last_d ? ST_RDATA : ST_DONE;
      default:  w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_rw <= RW_READ;
      r_addr <= '0;
      r_data <= '0;
      r_shift <= '0;
      r_last <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_next == r_state && r_state != ST_IDLE) ? r_cnt + 1'b1 : '0;
      if (r_state == ST_IDLE && sel && m_valid) r_rw <= m_rw;
      if (r_state == ST_ADDR) r_addr <= w_addr_sh;
      if (r_state == ST_WDATA) r_data <= w_data_sh;
      if (w_next == ST_RDATA) r_shift <= r_state == ST_RDATA ? w_rot : w_rdata;
      if (r_state == ST_RDATA && w_next == ST_DONE) r_last <= w_rot;
    end
  slave_regfile #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_regfile (
    .clk(clk),
    .reset(reset),
    .i_we(w_we),
    .i_waddr(r_addr),
    .i_wdata(w_data_sh),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );
  assign s_valid = r_state == ST_RDATA;
  assign s_sdata = s_valid & r_shift[0];
  assign s_ready = r_state == ST_DONE;
  assign slave_state = r_state;
  assign last_rdata = r_last;
endmodule

// File: tb/tb_bus_slave_responder.sv
// tb_bus_slave_responder: randomized bench checking two responders (2 and 0 wait states) against a timeline model
module tb_bus_slave_responder;
  localparam int A = 4;
  localparam int D = 8;
  logic clk = 0;
  logic reset = 1;
  logic sel[2], m_valid[2], m_rw[2], m_sdata[2], s_sdata[2], s_valid[2], s_ready[2];
  logic [2:0] slave_state[2];
  logic [7:0] last_rdata[2];
  int total = 0, bad = 0, cyc = 0;
  bit chk_on = 0;
  logic [7:0] mem[2][16];
  logic [7:0] mlast[2];
  logic [3:0] ma[2];
  logic [7:0] md[2];
  bit act[2], mrw[2];
  int t0[2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bus_slave_responder #(.ADDR_WIDTH(A), .DATA_WIDTH(D), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .reset(reset), .sel(sel[0]), .m_valid(m_valid[0]), .m_rw(m_rw[0]),
    .m_sdata(m_sdata[0]), .s_sdata(s_sdata[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .slave_state(slave_state[0]), .last_rdata(last_rdata[0])
  );
  bus_slave_responder #(.ADDR_WIDTH(A), .DATA_WIDTH(D), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .reset(reset), .sel(sel[1]), .m_valid(m_valid[1]), .m_rw(m_rw[1]),
    .m_sdata(m_sdata[1]), .s_sdata(s_sdata[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .slave_state(slave_state[1]), .last_rdata(last_rdata[1])
  );
  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", nm, k, cyc, got, want);
    end
  endtask
  function automatic logic [2:0] exp_state(input bit rw, input int o, input int w);
    if (o < 1) return 3'd0;
    if (o <= A) return 3'd1;
    if (rw) begin
      if (o <= A + D) return 3'd2;
      if (o <= A + D + w) return 3'd3;
      if (o == A + D + w + 1) return 3'd5;
    end else begin
      if (o <= A + w) return 3'd3;
      if (o <= A + w + D) return 3'd4;
      if (o == A + w + D + 1) return 3'd5;
    end
    return 3'd0;
  endfunction
  always @(negedge clk) begin
    int o, w, dn, bi;
    logic [2:0] es;
    for (int k = 0; k < 2; k++) begin
      w = k == 0 ? 2 : 0;
      dn = A + D + w + 1;
      o = cyc - t0[k];
      es = act[k] ? exp_state(mrw[k], o, w) : 3'd0;
      bi = es == 3'd4 ? o - (A + w + 1) : 0;
      if (chk_on) begin
        chk("state", k, 32'(slave_state[k]), 32'(es));
        chk("s_valid", k, 32'(s_valid[k]), 32'(es == 3'd4));
        chk("s_sdata", k, 32'(s_sdata[k]), 32'(es == 3'd4 ? mem[k][ma[k]][bi] : 1'b0));
        chk("s_ready", k, 32'(s_ready[k]), 32'(es == 3'd5));
        chk("last_rdata", k, 32'(last_rdata[k]), 32'(mlast[k]));
      end
      if (reset) begin
        act[k] = 0;
        mlast[k] = 8'h00;
        for (int j = 0; j < 16; j++) mem[k][j] = 8'h00;
      end else if (!act[k]) begin
        if (sel[k] && m_valid[k]) begin
          act[k] = 1;
          t0[k] = cyc;
          mrw[k] = m_rw[k];
        end
      end else begin
        if (o >= 1 && o <= A) ma[k][o-1] = m_sdata[k];
        if (mrw[k] && o > A && o <= A + D) md[k][o-1-A] = m_sdata[k];
        if (o < dn && !sel[k]) act[k] = 0;
        else begin
          if (mrw[k] && o == A + D) mem[k][ma[k]] = md[k];
          if (!mrw[k] && o == dn - 1) mlast[k] = mem[k][ma[k]];
          if (o == dn) act[k] = 0;
        end
      end
    end
  end
  task automatic gap(input int n, input bit noise);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        sel[k] = 0;
        m_valid[k] = noise ? 1'($urandom) : 1'b0;
        m_rw[k] = 1'($urandom);
        m_sdata[k] = 1'($urandom);
      end
    end
  endtask
  task automatic txn(input int k, input bit rw, input int a, input int d, input int ab, input int mvo,
                     input int rso, output int ro, output int fv, output logic [7:0] rb);
    int n;
    n = 0;
    ro = -1;
    fv = -1;
    rb = 8'h00;
    @(posedge clk);
    #1;
    sel[k] = 1;
    m_valid[k] = 1;
    m_rw[k] = rw;
    m_sdata[k] = 1'($urandom);
    for (int o = 1; o <= 40; o++) begin
      @(posedge clk);
      #1;
      m_valid[k] = (o == mvo);
      m_rw[k] = 1'($urandom);
      m_sdata[k] = o <= A ? a[o-1] : (rw && o <= A + D) ? d[o-1-A] : 1'($urandom);
      if (o == ab) sel[k] = 0;
      if (o == rso) reset = 1;
      if (rso > 0 && o == rso + 1) reset = 0;
      @(negedge clk);
      if (s_valid[k] && n < 8) begin
        if (fv < 0) fv = o;
        rb[n] = s_sdata[k];
        n++;
      end
      if (s_ready[k]) begin
        ro = o;
        break;
      end
      if (ab > 0 && o >= ab + 2) break;
      if (rso > 0 && o == rso + 1) break;
    end
  endtask
  initial begin
    int ro, fv, k, ab, mvo;
    logic [7:0] rb;
    bit rw;
    for (int i = 0; i < 2; i++) begin
      sel[i] = 0;
      m_valid[i] = 0;
      m_rw[i] = 0;
      m_sdata[i] = 0;
    end
    @(posedge clk);
    #1;
    chk_on = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    gap(20, 0);
    @(negedge clk);
    chk("idle_state", 0, 32'(slave_state[0]), 0);
    chk("idle_valid", 0, 32'(s_valid[0]), 0);
    chk("idle_ready", 0, 32'(s_ready[0]), 0);
    chk("idle_last", 0, 32'(last_rdata[0]), 0);
    txn(0, 0, 15, 0, 0, 0, 0, ro, fv, rb);
    chk("rdF_ready_cyc", 0, ro, 15);
    chk("rdF_data", 0, 32'(rb), 32'h00);
    chk("rdF_last", 0, 32'(last_rdata[0]), 32'h00);
    txn(0, 1, 3, 8'hA5, 0, 0, 0, ro, fv, rb);
    chk("wr3_ready_cyc", 0, ro, 15);
    txn(0, 0, 3, 0, 0, 0, 0, ro, fv, rb);
    chk("rd3_ready_cyc", 0, ro, 15);
    chk("rd3_first_valid", 0, fv, 7);
    chk("rd3_data", 0, 32'(rb), 32'hA5);
    chk("rd3_last", 0, 32'(last_rdata[0]), 32'hA5);
    gap(2, 0);
    txn(0, 1, 7, 8'h3C, 8, 0, 0, ro, fv, rb);
    chk("abort_no_ready", 0, ro, -1);
    chk("abort_idle", 0, 32'(slave_state[0]), 0);
    txn(0, 0, 7, 0, 0, 0, 0, ro, fv, rb);
    chk("rd7_data", 0, 32'(rb), 32'h00);
    txn(1, 1, 1, 8'h81, 0, 0, 0, ro, fv, rb);
    chk("w0_wr_ready_cyc", 1, ro, 13);
    txn(1, 0, 1, 0, 0, 0, 0, ro, fv, rb);
    chk("w0_rd_ready_cyc", 1, ro, 13);
    chk("w0_rd_first_valid", 1, fv, 5);
    chk("w0_rd_data", 1, 32'(rb), 32'h81);
    txn(0, 1, 9, 8'h5A, 0, 2, 0, ro, fv, rb);
    chk("strobe_ignored_ready", 0, ro, 15);
    txn(0, 0, 9, 0, 0, 0, 0, ro, fv, rb);
    chk("b2b_ready_cyc", 0, ro, 15);
    chk("b2b_data", 0, 32'(rb), 32'h5A);
    txn(0, 0, 3, 0, 0, 0, 10, ro, fv, rb);
    chk("rst_valid_drop", 0, 32'(s_valid[0]), 0);
    chk("rst_state", 0, 32'(slave_state[0]), 0);
    txn(0, 0, 3, 0, 0, 0, 0, ro, fv, rb);
    chk("rst_cleared_data", 0, 32'(rb), 32'h00);
    gap(3, 1);
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 1);
      rw = 1'($urandom);
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 14) : 0;
      mvo = $urandom_range(0, 14);
      txn(k, rw, $urandom_range(0, 15), $urandom_range(0, 255), ab, mvo, 0, ro, fv, rb);
      gap($urandom_range(0, 3), 1);
    end
    gap(4, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
